blob_centroid_tracker: RTL
==========================

Name: blob_centroid_tracker

Overview:
- Parametrised multi-channel colour tracker fed by the camera capture/processing pixel stream.
- Classifies each valid pixel against NUM_CH programmable RGB windows and accumulates per-channel x-sum, y-sum and pixel count over a frame.
- At frame end, computes each channel's centroid with a shared sequential divider.
- Presents the coordinates as a packed IPU-style output, e.g. two paddle positions for SuperPong.

Parameters:
- NUM_CH, 2: number of independent colour channels/objects tracked.
- IMG_W, 640: pixels per line.
- IMG_H, 480: lines per frame.
- MIN_PIX, 16: minimum matching pixels for a channel to count as found.
- Derived localparams: CW = clog2(max(IMG_W,IMG_H)) (10); NW = clog2(IMG_W*IMG_H+1) (19); SW = CW+NW (29).

Ports:
- CLK  in  1  system clock, the only clock.
- RESET  in  1  asynchronous, active-high reset.
- frame_start  in  1  one-cycle pulse at start of frame; clears x/y position counters.
- frame_end  in  1  one-cycle pulse after the last pixel; triggers centroid computation.
- pix_valid  in  1  qualifies pix_r/g/b for one pixel in raster order.
- pix_r  in  5  red component.
- pix_g  in  5  green component (5 MSBs).
- pix_b  in  5  blue component.
- th_lo  in  NUM_CH*15  per-channel lower bounds {r,g,b}; channel i at [15i+14:15i].
- th_hi  in  NUM_CH*15  per-channel upper bounds, same packing.
- coord_out  out  NUM_CH*2*CW  channel i = {y,x} at [2CW(i+1)-1:2CWi].
- ch_found  out  NUM_CH  per-channel found flag for last completed frame.
- coord_valid  out  1  one-cycle pulse when coord_out/ch_found update.
- busy  out  1  divider running.
- frame_drop  out  1  one-cycle pulse when frame_end arrives while busy.

Behaviour:
- Reset (async, active-high): all outputs 0, x=y=0, accumulators 0, FSM to IDLE.
- Position counters:
  - frame_start sets x=0, y=0.
  - Each pix_valid advances x; when x==IMG_W-1, x wraps to 0 and y increments.
  - At y==IMG_H-1 with x wrap, y holds IMG_H-1 and further pixels in that frame are ignored (not accumulated).
- Match rule: channel i matches when th_lo component <= pixel component <= th_hi component for all of r, g and b (inclusive, unsigned). A pixel may match several channels.
- Accumulate on match: sum_x[i] += x, sum_y[i] += y, cnt[i] += 1. Widths are SW/SW/NW; no overflow is possible within one frame.
- frame_end while IDLE:
  - Next edge copies all accumulators to snapshot registers and clears the live accumulators.
  - A pix_valid in the same cycle as frame_end belongs to the ending frame and is included in the snapshot.
  - FSM enters DIV; busy=1.
- frame_end while busy:
  - Live accumulators are cleared; that frame's data is discarded.
  - frame_drop pulses 1 cycle; the running division continues unaffected.
- FSM states:
  - IDLE: waits for frame_end.
  - LATCH: 1 cycle.
  - LOAD: 1 cycle; selects the dividend (sum_x then sum_y for ch0, then ch1, ...) and the divisor cnt.
  - ITER: CW cycles; restoring shift-subtract, 1 quotient bit/cycle, MSB first.
  - STORE: writes the quotient into the result register. Returns to LOAD until all 2*NUM_CH divisions are done, then goes to DONE.
  - DONE: 1 cycle; updates coord_out/ch_found, pulses coord_valid, goes to IDLE.
- Latency: coord_valid is high exactly L = 2*NUM_CH*(CW+2)+2 cycles after the cycle frame_end was sampled high. Defaults give L = 50.
- Quotient = floor(sum/cnt), truncated to CW bits; it is always < IMG_W or IMG_H.
- cnt < MIN_PIX (including 0): ch_found[i]=0 and coord_out for that channel holds its previous value. The division still runs its slot (fixed latency); the cnt==0 divisor yields a don't-care quotient that is discarded.
- cnt >= MIN_PIX: ch_found[i]=1, coord_out updated.
- coord_out/ch_found change only in DONE; they are stable between coord_valid pulses.
- Reset mid-division: immediate return to IDLE, all outputs 0, no coord_valid.

Test Plan:
1. Channel 0 window lo={31,0,0}, hi={31,4,4}. 640x480 frame, red pixels at x 100..109, y 200..209 (cnt 100), others black. Required: coord_valid 50 cycles after frame_end; ch0 {y,x}={204,104}; ch_found=2'b01; ch1 coord=0.
2. Two channels: ch0 red block as in 1, ch1 green window with one pixel block at x 600..603, y 10..13. Required: ch0 (104,204), ch1 (601,11), ch_found=2'b11.
3. Ch0 sees only 15 matching pixels in frame 2 after a valid frame 1. Required: ch_found[0]=0 and ch0 coord unchanged from frame 1.
4. Second frame_end 20 cycles after the first. Required: frame_drop pulses once, first result still appears at +50 carrying frame 1 data, next frame accumulates from zero.
5. Matching pixel asserted in the same cycle as frame_end, single-pixel frame at (7,3) with MIN_PIX=1. Required: centroid (7,3), found.
6. RESET pulsed 10 cycles into DIV. Required: busy=0 and outputs 0 immediately, no coord_valid; next full frame produces a correct result.

Source files
------------

// File: rtl/blob_centroid_tracker.sv
// -----------------------------------------------------------------------------
// blob_centroid_tracker
//
// Multi-channel colour-blob tracker fed by a raster pixel stream. Each valid
// pixel is tested against NUM_CH programmable RGB boxes. Every matching channel
// adds the pixel's x and y to its sums and increments its pixel count. At frame
// end the sums are snapshotted. One shared restoring divider then computes
// floor(sum/cnt) for x and y of every channel, one quotient bit per cycle.
// The coordinates are published together with a per-channel found flag.
//
// Ports
//   CLK          system clock
//   RESET        asynchronous, active-high reset
//   frame_start  1-cycle pulse, restarts the raster position at (0,0)
//   frame_end    1-cycle pulse after the last pixel, starts the centroid pass
//   pix_valid    qualifies pix_r/pix_g/pix_b (raster order)
//   pix_r/g/b    5-bit colour components
//   th_lo/th_hi  per-channel inclusive bounds {r,g,b}, channel i at [15i+14:15i]
//   coord_out    channel i = {y,x} at [2CW(i+1)-1:2CWi]
//   ch_found     channel had at least MIN_PIX matching pixels in the last frame
//   coord_valid  1-cycle pulse when coord_out/ch_found update
//   busy         centroid computation in progress
//   frame_drop   1-cycle pulse when a frame_end arrived while busy
// -----------------------------------------------------------------------------
module blob_centroid_tracker #(
  parameter int NUM_CH  = 2,
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int MIN_PIX = 16,
  localparam int CW = $clog2((IMG_W > IMG_H) ? IMG_W : IMG_H),
  localparam int NW = $clog2(IMG_W * IMG_H + 1),
  localparam int SW = CW + NW
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   frame_start,
  input  logic                   frame_end,
  input  logic                   pix_valid,
  input  logic [4:0]             pix_r,
  input  logic [4:0]             pix_g,
  input  logic [4:0]             pix_b,
  input  logic [NUM_CH*15-1:0]   th_lo,
  input  logic [NUM_CH*15-1:0]   th_hi,
  output logic [NUM_CH*2*CW-1:0] coord_out,
  output logic [NUM_CH-1:0]      ch_found,
  output logic                   coord_valid,
  output logic                   busy,
  output logic                   frame_drop
);

  localparam int NSLOT = 2 * NUM_CH;
  localparam int SLW   = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam int IW    = $clog2(CW + 1);

  localparam logic [CW-1:0]  X_LAST    = CW'(IMG_W - 1);
  localparam logic [CW-1:0]  Y_LAST    = CW'(IMG_H - 1);
  localparam logic [NW-1:0]  MIN_CNT   = NW'(MIN_PIX);
  localparam logic [SLW-1:0] SLOT_LAST = SLW'(NSLOT - 1);
  localparam logic [IW-1:0]  ITER_LAST = IW'(CW - 1);

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Inclusive unsigned box test over the three 5-bit components.
  function automatic logic in_window(input logic [14:0] px,
                                     input logic [14:0] lo,
                                     input logic [14:0] hi);
    logic ok;
    ok = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if ((px[5*c +: 5] < lo[5*c +: 5]) || (px[5*c +: 5] > hi[5*c +: 5]))
        ok = 1'b0;
    end
    return ok;
  endfunction

  // One restoring-division step: returns {quotient_bit, new_remainder}.
  // The remainder is always below the divisor, so it fits in NW bits.
  function automatic logic [NW:0] div_step(input logic [NW-1:0] rem,
                                           input logic          din,
                                           input logic [NW-1:0] dvsr);
    logic [NW:0] trial;
    logic [NW:0] diff;
    trial = {rem, din};
    diff  = trial - {1'b0, dvsr};
    if (trial >= {1'b0, dvsr})
      return {1'b1, diff[NW-1:0]};
    else
      return {1'b0, trial[NW-1:0]};
  endfunction

  // ---------------------------------------------------------------------------
  // FSM declarations and control strobes
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_LOAD, S_ITER, S_STORE, S_DONE
  } state_t;

  state_t         state, state_nxt;
  logic [SLW-1:0] slot;
  logic [IW-1:0]  iter;
  logic           latch_en, drop_en, load_en, iter_en, store_en, last_store;

  // ---------------------------------------------------------------------------
  // Stage p0: raster position and per-channel classification (combinational)
  // ---------------------------------------------------------------------------
  logic [CW-1:0]     x_cur, y_cur;
  logic              frame_over;
  logic [14:0]       pix_rgb;
  logic [CW-1:0]     pos_x_p0, pos_y_p0;
  logic              vld_p0;
  logic [NUM_CH-1:0] hit_p0;

  // A pixel arriving together with frame_start is treated as the pixel at (0,0).
  always_comb begin
    pix_rgb  = {pix_r, pix_g, pix_b};
    pos_x_p0 = frame_start ? '0 : x_cur;
    pos_y_p0 = frame_start ? '0 : y_cur;
    vld_p0   = pix_valid && (frame_start || !frame_over);
    for (int i = 0; i < NUM_CH; i++)
      hit_p0[i] = vld_p0 && in_window(pix_rgb, th_lo[15*i +: 15], th_hi[15*i +: 15]);
  end

  // frame_over marks that the last raster position has been consumed; any
  // further pixels in the frame are ignored rather than folded into row IMG_H-1.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      x_cur      <= '0;
      y_cur      <= '0;
      frame_over <= 1'b0;
    end else if (vld_p0) begin
      if (pos_x_p0 == X_LAST) begin
        x_cur <= '0;
        if (pos_y_p0 == Y_LAST) begin
          y_cur      <= pos_y_p0;
          frame_over <= 1'b1;
        end else begin
          y_cur      <= pos_y_p0 + CW'(1);
          frame_over <= 1'b0;
        end
      end else begin
        x_cur      <= pos_x_p0 + CW'(1);
        y_cur      <= pos_y_p0;
        frame_over <= 1'b0;
      end
    end else if (frame_start) begin
      x_cur      <= '0;
      y_cur      <= '0;
      frame_over <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p1: live per-channel accumulators
  // ---------------------------------------------------------------------------
  logic [SW-1:0] acc_sx_p1 [NUM_CH];
  logic [SW-1:0] acc_sy_p1 [NUM_CH];
  logic [NW-1:0] acc_n_p1  [NUM_CH];
  logic [SW-1:0] sum_sx_nxt [NUM_CH];
  logic [SW-1:0] sum_sy_nxt [NUM_CH];
  logic [NW-1:0] sum_n_nxt  [NUM_CH];

  // The "next" values include the current pixel so that a pixel coincident
  // with frame_end lands in the snapshot.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      sum_sx_nxt[i] = acc_sx_p1[i] + (hit_p0[i] ? SW'(pos_x_p0) : '0);
      sum_sy_nxt[i] = acc_sy_p1[i] + (hit_p0[i] ? SW'(pos_y_p0) : '0);
      sum_n_nxt[i]  = acc_n_p1[i]  + NW'(hit_p0[i]);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_sx_p1[i] <= '0;
        acc_sy_p1[i] <= '0;
        acc_n_p1[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (frame_end) begin
          acc_sx_p1[i] <= '0;
          acc_sy_p1[i] <= '0;
          acc_n_p1[i]  <= '0;
        end else begin
          acc_sx_p1[i] <= sum_sx_nxt[i];
          acc_sy_p1[i] <= sum_sy_nxt[i];
          acc_n_p1[i]  <= sum_n_nxt[i];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p2: frame snapshot feeding the shared divider
  // ---------------------------------------------------------------------------
  logic [SW-1:0] snap_sx_p2 [NUM_CH];
  logic [SW-1:0] snap_sy_p2 [NUM_CH];
  logic [NW-1:0] snap_n_p2  [NUM_CH];

  always_ff @(posedge CLK) begin
    if (latch_en) begin
      for (int i = 0; i < NUM_CH; i++) begin
        snap_sx_p2[i] <= sum_sx_nxt[i];
        snap_sy_p2[i] <= sum_sy_nxt[i];
        snap_n_p2[i]  <= sum_n_nxt[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register / next-state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (frame_end) state_nxt = S_LATCH;
      S_LATCH: state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_ITER;
      S_ITER:  if (iter == ITER_LAST) state_nxt = S_STORE;
      S_STORE: state_nxt = (slot == SLOT_LAST) ? S_DONE : S_LOAD;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != S_IDLE);
    latch_en   = (state == S_IDLE) && frame_end;
    drop_en    = (state != S_IDLE) && frame_end;
    load_en    = (state == S_LOAD);
    iter_en    = (state == S_ITER);
    store_en   = (state == S_STORE);
    last_store = (state == S_STORE) && (slot == SLOT_LAST);
  end

  // Slot k: channel k/2, x for even k and y for odd k.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      slot <= '0;
      iter <= '0;
    end else begin
      if (state == S_LATCH) slot <= '0;
      else if (store_en)    slot <= slot + SLW'(1);
      if (load_en)          iter <= '0;
      else if (iter_en)     iter <= iter + IW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Shared restoring divider
  // ---------------------------------------------------------------------------
  logic [SW-1:0] dividend;
  logic [NW-1:0] divisor;
  logic [NW-1:0] rem;
  logic [CW-1:0] dvd_lo;
  logic [NW-1:0] dvsr;
  logic [CW-1:0] quot;
  logic [NW:0]   step_out;
  logic [CW-1:0] res     [NSLOT];
  logic [CW-1:0] res_fin [NSLOT];
  logic [NUM_CH-1:0] found_nxt;

  always_comb begin
    dividend = '0;
    divisor  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (slot == SLW'(2*i)) begin
        dividend = snap_sx_p2[i];
        divisor  = snap_n_p2[i];
      end
      if (slot == SLW'(2*i + 1)) begin
        dividend = snap_sy_p2[i];
        divisor  = snap_n_p2[i];
      end
    end
  end

  // The quotient always fits in CW bits, i.e. dividend[SW-1:CW] < divisor, so
  // the upper part can preload the remainder and only CW steps are needed.
  // A zero divisor just produces a garbage quotient that is never published.
  assign step_out = div_step(rem, dvd_lo[CW-1], dvsr);

  always_ff @(posedge CLK) begin
    if (load_en) begin
      rem    <= dividend[SW-1:CW];
      dvd_lo <= dividend[CW-1:0];
      dvsr   <= divisor;
      quot   <= '0;
    end else if (iter_en) begin
      rem    <= step_out[NW-1:0];
      dvd_lo <= {dvd_lo[CW-2:0], 1'b0};
      quot   <= {quot[CW-2:0], step_out[NW]};
    end
    for (int k = 0; k < NSLOT; k++) begin
      if (store_en && (slot == SLW'(k))) res[k] <= quot;
    end
  end

  // The last quotient is still in flight on the final STORE edge, so the
  // published results bypass it straight from the divider.
  always_comb begin
    for (int k = 0; k < NSLOT; k++)
      res_fin[k] = (store_en && (slot == SLW'(k))) ? quot : res[k];
    for (int i = 0; i < NUM_CH; i++)
      found_nxt[i] = (snap_n_p2[i] >= MIN_CNT);
  end

  // ---------------------------------------------------------------------------
  // Output registers: valid during the DONE cycle
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      coord_out   <= '0;
      ch_found    <= '0;
      coord_valid <= 1'b0;
      frame_drop  <= 1'b0;
    end else begin
      coord_valid <= last_store;
      frame_drop  <= drop_en;
      if (last_store) begin
        ch_found <= found_nxt;
        for (int i = 0; i < NUM_CH; i++) begin
          if (found_nxt[i])
            coord_out[2*CW*i +: 2*CW] <= {res_fin[2*i + 1], res_fin[2*i]};
        end
      end
    end
  end

endmodule
